// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared states and framing constants for the serial transmitter
package serial_tx_pkg;
  typedef enum logic [2:0] {IDLE, PREP, LOAD, START, DATA, STOP, PARITY} state_t;
  localparam int DATA_BITS = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: bit-period counter with clear and a terminal-count flag at CLKS_PER_BIT-1
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W = 16
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic clear,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = cnt == CNT_W'(CLKS_PER_BIT - 1);
  // count up, restarting on clear or after the terminal count so it never exceeds CLKS_PER_BIT-1
  always_ff @(posedge CLOCK_50) begin
    cnt <= (Reset || clear || tc) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx_controller.sv
// serial_tx_controller: sequences a PISO into start/data/stop frames; define SERIAL_TX_PARITY_EN for an even parity bit
module serial_tx_controller
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W = 16
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic [7:0] Piso_Parallel_Data,
  output logic       Piso_Load,
  output logic       Piso_Shift,
  input  logic       Piso_Serial_In,
  output logic       Tx_Line,
  output logic       Busy
);
  state_t state, state_n;
  logic [7:0] hold;
  logic [2:0] idx;
  logic tc, last, tail_line;
  assign last = idx == 3'(DATA_BITS - 1);
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_timer (
    .CLOCK_50(CLOCK_50),
    .Reset(Reset),
    .clear(state_n != state),
    .tc(tc)
  );
`ifdef SERIAL_TX_PARITY_EN
  assign tail_line = state == PARITY ? ^hold : STOP_LEVEL;
`else
  assign tail_line = STOP_LEVEL;
`endif
  // state register, held byte and data bit index
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= IDLE;
      hold <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && Tx_Valid) hold <= Tx_Data;
      idx <= state != DATA ? '0 : tc ? idx + 1'b1 : idx;
    end
  end
  // next state and Moore output decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = Tx_Valid ? PREP : IDLE;
      PREP:   state_n = LOAD;
      LOAD:   state_n = START;
      START:  state_n = tc ? DATA : START;
`ifdef SERIAL_TX_PARITY_EN
      DATA:   state_n = tc && last ? PARITY : DATA;
      PARITY: state_n = tc ? STOP : PARITY;
`else
      DATA:   state_n = tc && last ? STOP : DATA;
`endif
      STOP:   state_n = tc ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    Tx_Ready = state == IDLE;
    Busy = state != IDLE;
    Piso_Load = state == LOAD;
    Piso_Shift = state == DATA && tc && !last;
    Piso_Parallel_Data = hold;
    Tx_Line = state == START ? START_LEVEL : state == DATA ? Piso_Serial_In : tail_line;
  end
endmodule

// File: tb/tb_serial_tx_controller.sv
// tb_serial_tx_controller: scoreboard bench with a PISO model at CLKS_PER_BIT=4 and 2
module tb_serial_tx_controller;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic [1:0] rst, valid, ready, line, busy, load, shift, sin;
  logic [7:0] data [2];
  logic [7:0] pdata [2];
  logic [7:0] q [2][$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int C = (g == 0) ? 4 : 2;
    logic [7:0] inr = '0, sr = '0;
    serial_tx_controller #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
      .CLOCK_50(clk),
      .Reset(rst[g]),
      .Tx_Data(data[g]),
      .Tx_Valid(valid[g]),
      .Tx_Ready(ready[g]),
      .Piso_Parallel_Data(pdata[g]),
      .Piso_Load(load[g]),
      .Piso_Shift(shift[g]),
      .Piso_Serial_In(sin[g]),
      .Tx_Line(line[g]),
      .Busy(busy[g])
    );
    always @(posedge clk) begin
      inr <= pdata[g];
      if (load[g]) sr <= inr;
      else if (shift[g]) sr <= {1'b0, sr[7:1]};
    end
    assign sin[g] = sr[0];

    initial begin
      int cyc, acc, fc, nsh;
      logic inf, post, pl, glitch, shbad, bsy, ovl;
      logic [10:0] bits;
      logic [7:0] e;
      cyc = 0; acc = -100; fc = 0; nsh = 0;
      inf = 0; post = 0; pl = 0; glitch = 0; shbad = 0; bsy = 0; ovl = 0; bits = '0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rst[g]) begin
          if (inf) e = q[g].pop_front();
          inf = 0;
          post = 0;
        end else begin
          if (post) begin
            chk($sformatf("idle_after_frame%0d", g), {29'd0, busy[g], ready[g], line[g]}, 3'b011);
            post = 0;
          end
          if (load[g] && shift[g]) ovl = 1;
          if (valid[g] && ready[g]) acc = cyc;
          if (!inf && line[g] == 1'b0) begin
            inf = 1; fc = 0; nsh = 0; shbad = 0; glitch = 0; bsy = 0; bits = '0;
            chk($sformatf("start_latency%0d", g), 32'(cyc - acc), 3);
            chk($sformatf("load_before_start%0d", g), {31'd0, pl}, 1);
          end
          if (inf) begin
            if (fc % C == 0) bits[fc / C] = line[g];
            else if (line[g] !== bits[fc / C]) glitch = 1;
            if (shift[g]) begin
              nsh++;
              if (fc % C != C - 1 || fc < 2 * C - 1 || fc > 8 * C - 1) shbad = 1;
            end
            if (load[g]) shbad = 1;
            if (!busy[g] || ready[g]) bsy = 1;
            fc++;
            if (fc == NB * C) begin
              inf = 0;
              post = 1;
              if (q[g].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame%0d: got bits %0h expected no frame", g, bits);
              end else begin
                e = q[g].pop_front();
                chk($sformatf("frame%0d_%0h", g, e), {21'd0, bits}, {21'd0, frame_of(e)});
                chk($sformatf("shift_count%0d", g), nsh, 7);
                chk($sformatf("strobe_timing%0d", g), {28'd0, shbad, glitch, bsy, ovl}, 0);
              end
              ovl = 0;
            end
          end
        end
        pl = load[g];
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    int k;
    k = 0;
    while (!ready[i] && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 2000) chk("ready_timeout", 0, 1);
    q[i].push_back(b);
    valid[i] = 1'b1;
    data[i] = b;
    @(posedge clk); #1;
    valid[i] = 1'b0;
    data[i] = 8'($urandom);
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (q[i].size() != 0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", q[i].size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic bad;
    rst = 2'b11; valid = 2'b00; data[0] = '0; data[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", {27'd0, ready[i], line[i], busy[i], load[i], shift[i]}, 5'b11000);
      chk("reset_hold", {24'd0, pdata[i]}, 0);
    end

    send(0, 8'hA5);
    drain(0);

    send(0, 8'h5A);
    repeat (17) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    chk("reset_mid_data", {29'd0, ready[0], line[0], busy[0]}, 3'b110);
    chk("reset_hold_cleared", {24'd0, pdata[0]}, 0);
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      bad = bad | load[0] | shift[0] | !line[0] | !ready[0];
    end
    chk("quiet_after_reset", {31'd0, bad}, 0);
    chk("aborted_discarded", q[0].size(), 0);

    q[0].push_back(8'h00);
    q[0].push_back(8'hFF);
    valid[0] = 1'b1;
    data[0] = 8'h00;
    @(posedge clk); #1;
    data[0] = 8'hFF;
    k = 0;
    while (!ready[0] && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); k++; #1;
    valid[0] = 1'b0;
    chk("accept_spacing", k, 43);
    drain(0);

    send(0, 8'h3C);
    repeat (10) @(posedge clk);
    #1 valid[0] = 1'b1; data[0] = 8'hC3;
    chk("busy_not_ready", {30'd0, ready[0], busy[0]}, 2'b01);
    @(posedge clk); #1 valid[0] = 1'b0;
    chk("hold_unchanged", {24'd0, pdata[0]}, 8'h3C);
    drain(0);

    send(0, 8'h07);
    drain(0);

    send(1, 8'h01);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
